// File: rtl/iob_regfile_mp.sv
// Multi-port register file: N_W masked write ports, N_R read ports, optional read register and bypass.
// Latency: RD_REG=1 gives read data one cycle after the request edge; RD_REG=0 reads combinationally.
// Backpressure: none; every request is accepted on each enabled edge, and cke_i=0 freezes all state.
//
// Ports:
//   clk_i, arst_i (async active-high), cke_i (clock enable), rst_i (sync clear, qualified by cke_i)
//   we_i/waddr_i/wmask_i/wdata_i : per write port, port p in slice p
//   re_i/raddr_i                 : per read port request
//   rdata_o/rvalid_o             : per read port result
//   wconflict_o                  : registered flag, two or more enabled writes hit one address
module iob_regfile_mp #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 21,
    parameter int N_W    = 2,
    parameter int N_R    = 2,
    parameter int RD_REG = 1,
    parameter int BYPASS = 1
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     cke_i,
    input  logic                     rst_i,
    input  logic [N_W-1:0]           we_i,
    input  logic [N_W*ADDR_W-1:0]    waddr_i,
    input  logic [N_W*DATA_W-1:0]    wmask_i,
    input  logic [N_W*DATA_W-1:0]    wdata_i,
    input  logic [N_R-1:0]           re_i,
    input  logic [N_R*ADDR_W-1:0]    raddr_i,
    output logic [N_R*DATA_W-1:0]    rdata_o,
    output logic [N_R-1:0]           rvalid_o,
    output logic                     wconflict_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q   [DEPTH];
    logic [DATA_W-1:0] mem_nxt [DEPTH];
    logic              wconflict_nxt;
    logic              wconflict_q;

    // Post-write image of the array. Ports are merged in ascending order so a
    // higher-index port overrides lower ones only on the bits it actually masks.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt[i] = mem_q[i];
        end
        for (int p = 0; p < N_W; p++) begin
            if (we_i[p]) begin
                mem_nxt[waddr_i[p*ADDR_W +: ADDR_W]] =
                    (mem_nxt[waddr_i[p*ADDR_W +: ADDR_W]] & ~wmask_i[p*DATA_W +: DATA_W]) |
                    (wdata_i[p*DATA_W +: DATA_W] & wmask_i[p*DATA_W +: DATA_W]);
            end
        end
    end

    // Collision depends only on enables and addresses; masks are ignored.
    always_comb begin
        wconflict_nxt = 1'b0;
        for (int p = 0; p < N_W; p++) begin
            for (int q = p + 1; q < N_W; q++) begin
                if (we_i[p] && we_i[q] &&
                    (waddr_i[p*ADDR_W +: ADDR_W] == waddr_i[q*ADDR_W +: ADDR_W])) begin
                    wconflict_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wconflict_q <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                wconflict_q <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= mem_nxt[i];
                end
                wconflict_q <= wconflict_nxt;
            end
        end
    end

    assign wconflict_o = wconflict_q;

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [N_R*DATA_W-1:0] rdata_q;
            logic [N_R-1:0]        rvalid_q;

            // BYPASS selects the merged post-write image, otherwise the stored value.
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    rdata_q  <= '0;
                    rvalid_q <= '0;
                end else if (cke_i) begin
                    if (rst_i) begin
                        rdata_q  <= '0;
                        rvalid_q <= '0;
                    end else begin
                        rvalid_q <= re_i;
                        for (int r = 0; r < N_R; r++) begin
                            if (re_i[r]) begin
                                rdata_q[r*DATA_W +: DATA_W] <= (BYPASS != 0) ?
                                    mem_nxt[raddr_i[r*ADDR_W +: ADDR_W]] :
                                    mem_q[raddr_i[r*ADDR_W +: ADDR_W]];
                            end
                        end
                    end
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end else begin : g_rd_comb
            always_comb begin
                rdata_o = '0;
                for (int r = 0; r < N_R; r++) begin
                    rdata_o[r*DATA_W +: DATA_W] = mem_q[raddr_i[r*ADDR_W +: ADDR_W]];
                end
            end

            assign rvalid_o = re_i;
        end
    endgenerate

endmodule

// File: tb/tb_iob_regfile_mp.sv
// Bench for iob_regfile_mp: bypass build, non-bypass build and combinational-read build share stimulus.
// Latency: reads of the registered builds are checked one edge after the request.
// Backpressure: none; stimulus is applied every cycle.
module tb_iob_regfile_mp;

    logic        clk;
    logic        arst;
    logic        cke;
    logic        rst;
    logic [1:0]  we;
    logic [3:0]  waddr;
    logic [15:0] wmask;
    logic [15:0] wdata;
    logic [1:0]  re;
    logic [3:0]  raddr;

    logic [15:0] rdata,   rdata_nb,   rdata_c;
    logic [1:0]  rvalid,  rvalid_nb,  rvalid_c;
    logic        wconf,   wconf_nb,   wconf_c;

    iob_regfile_mp #(.ADDR_W(2), .DATA_W(8), .N_W(2), .N_R(2), .RD_REG(1), .BYPASS(1)) u_dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
        .we_i(we), .waddr_i(waddr), .wmask_i(wmask), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata), .rvalid_o(rvalid), .wconflict_o(wconf)
    );

    iob_regfile_mp #(.ADDR_W(2), .DATA_W(8), .N_W(2), .N_R(2), .RD_REG(1), .BYPASS(0)) u_dut_nb (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
        .we_i(we), .waddr_i(waddr), .wmask_i(wmask), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata_nb), .rvalid_o(rvalid_nb), .wconflict_o(wconf_nb)
    );

    iob_regfile_mp #(.ADDR_W(2), .DATA_W(8), .N_W(2), .N_R(2), .RD_REG(0), .BYPASS(1)) u_dut_comb (
        .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
        .we_i(we), .waddr_i(waddr), .wmask_i(wmask), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr),
        .rdata_o(rdata_c), .rvalid_o(rvalid_c), .wconflict_o(wconf_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state
    logic [7:0] model [4];
    logic [7:0] exp_rdata [2];
    logic [7:0] exp_rdata_nb [2];
    logic [1:0] exp_rvalid;
    logic       exp_conf;
    logic [7:0] rq  [$];
    logic [7:0] nbq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int r = 0; r < 2; r++) begin
            exp_rdata[r]    = 8'h00;
            exp_rdata_nb[r] = 8'h00;
        end
        exp_rvalid = 2'b00;
        exp_conf   = 1'b0;
        rq.delete();
        nbq.delete();
    endtask

    task automatic set_idle();
        we = 2'b00; waddr = 4'h0; wmask = 16'h0; wdata = 16'h0;
        re = 2'b00; raddr = 4'h0; rst = 1'b0; cke = 1'b1;
    endtask

    // Predict the coming edge, apply it, then check every build.
    task automatic step(input string tag);
        logic [7:0] nxt [4];
        logic [7:0] pre [4];
        logic [1:0] a;
        logic [7:0] m, d;
        for (int i = 0; i < 4; i++) begin
            nxt[i] = model[i];
            pre[i] = model[i];
        end
        if (cke) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) nxt[i] = 8'h00;
                for (int r = 0; r < 2; r++) begin
                    exp_rdata[r]    = 8'h00;
                    exp_rdata_nb[r] = 8'h00;
                end
                exp_rvalid = 2'b00;
                exp_conf   = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (we[p]) begin
                        a = waddr[p*2 +: 2];
                        m = wmask[p*8 +: 8];
                        d = wdata[p*8 +: 8];
                        nxt[a] = (nxt[a] & ~m) | (d & m);
                    end
                end
                exp_conf = we[0] && we[1] && (waddr[1:0] == waddr[3:2]);
                for (int r = 0; r < 2; r++) begin
                    exp_rvalid[r] = re[r];
                    if (re[r]) begin
                        rq.push_back(nxt[raddr[r*2 +: 2]]);
                        nbq.push_back(pre[raddr[r*2 +: 2]]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) model[i] = nxt[i];

        @(posedge clk);
        @(negedge clk);

        for (int r = 0; r < 2; r++) begin
            if (exp_rvalid[r] && rq.size() > 0 && nbq.size() > 0) begin
                exp_rdata[r]    = rq.pop_front();
                exp_rdata_nb[r] = nbq.pop_front();
            end
            chk({tag, "_rvalid"},    32'(rvalid[r]),            32'(exp_rvalid[r]));
            chk({tag, "_rdata"},     32'(rdata[r*8 +: 8]),      32'(exp_rdata[r]));
            chk({tag, "_rvalid_nb"}, 32'(rvalid_nb[r]),         32'(exp_rvalid[r]));
            chk({tag, "_rdata_nb"},  32'(rdata_nb[r*8 +: 8]),   32'(exp_rdata_nb[r]));
            chk({tag, "_rdata_c"},   32'(rdata_c[r*8 +: 8]),    32'(model[raddr[r*2 +: 2]]));
        end
        chk({tag, "_rvalid_c"}, 32'(rvalid_c), 32'(re));
        chk({tag, "_wconf"},    32'(wconf),    32'(exp_conf));
        chk({tag, "_wconf_nb"}, 32'(wconf_nb), 32'(exp_conf));
        chk({tag, "_wconf_c"},  32'(wconf_c),  32'(exp_conf));
    endtask

    initial begin
        arst = 1'b1;
        set_idle();
        clear_ref();

        // Reset state, before any clock edge
        #3;
        chk("rst_rdata",  32'(rdata),  32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_wconf",  32'(wconf),  32'h0);
        chk("rst_rdata_c", 32'(rdata_c), 32'h0);
        @(negedge clk);
        arst = 1'b0;

        // Single write, read one cycle later, then valid drops and data holds
        we = 2'b01; waddr = 4'h1; wdata = 16'h00A5; wmask = 16'h00FF;
        step("wr_a5");
        set_idle(); re = 2'b10; raddr = 4'b0100;
        step("rd_a5");
        chk("rd_a5_const", 32'(rdata[15:8]), 32'h0000_00A5);
        set_idle();
        step("rd_a5_drop");
        chk("rd_a5_hold", 32'(rdata[15:8]), 32'h0000_00A5);

        // Both ports hit entry 2 with different masks
        we = 2'b11; waddr = 4'b1010; wdata = 16'hF00F; wmask = 16'hF0FF;
        step("coll");
        chk("coll_flag", 32'(wconf), 32'h1);
        set_idle(); re = 2'b01; raddr = 4'b0010;
        step("coll_rd");
        chk("coll_merge", 32'(rdata[7:0]), 32'h0000_00FF);

        // Collision flag ignores masks
        we = 2'b11; waddr = 4'b0000; wdata = 16'h1234; wmask = 16'h0000;
        step("coll_nomask");

        // Same-edge read/write: bypass vs pre-write value
        set_idle(); we = 2'b01; waddr = 4'h3; wdata = 16'h0011; wmask = 16'h00FF;
        step("wr_11");
        we = 2'b01; waddr = 4'h3; wdata = 16'h0022; wmask = 16'h00FF;
        re = 2'b11; raddr = 4'b1111;
        step("byp");
        chk("byp_new",  32'(rdata[7:0]),     32'h0000_0022);
        chk("byp_old",  32'(rdata_nb[15:8]), 32'h0000_0011);

        // Combinational read build: same-cycle data and valid
        set_idle(); we = 2'b01; waddr = 4'h0; wdata = 16'h003C; wmask = 16'h00FF;
        step("wr_3c");
        set_idle(); re = 2'b01; raddr = 4'h0;
        #1;
        chk("comb_data",  32'(rdata_c[7:0]), 32'h0000_003C);
        chk("comb_valid", 32'(rvalid_c[0]),  32'h1);
        step("comb_rd");

        // Random masked traffic
        for (int k = 0; k < 40; k++) begin
            we    = 2'($urandom);
            waddr = 4'($urandom);
            wmask = 16'($urandom);
            wdata = 16'($urandom);
            re    = 2'($urandom);
            raddr = 4'($urandom);
            step("rnd");
        end

        // Fill every entry, then freeze with cke low while writes and rst are active
        set_idle(); we = 2'b11; waddr = 4'b0100; wdata = 16'h2110; wmask = 16'hFFFF;
        step("fill01");
        we = 2'b11; waddr = 4'b1110; wdata = 16'h4332; wmask = 16'hFFFF;
        step("fill23");
        cke = 1'b0; rst = 1'b1; we = 2'b11; waddr = 4'b0100; wdata = 16'hEEEE; wmask = 16'hFFFF;
        re = 2'b11; raddr = 4'b1000;
        step("cke_hold");
        set_idle(); re = 2'b11; raddr = 4'b0100;
        step("chk01");
        set_idle(); re = 2'b11; raddr = 4'b1110;
        step("chk23");
        chk("fill_e2", 32'(rdata[7:0]),  32'h0000_0032);
        chk("fill_e3", 32'(rdata[15:8]), 32'h0000_0043);

        // Async reset in the middle of a pending read
        re = 2'b11; raddr = 4'b0001;
        #2 arst = 1'b1;
        #1;
        chk("arst_rdata",  32'(rdata),    32'h0);
        chk("arst_rvalid", 32'(rvalid),   32'h0);
        chk("arst_nb",     32'(rdata_nb), 32'h0);
        chk("arst_comb",   32'(rdata_c),  32'h0);
        clear_ref();
        @(negedge clk);
        arst = 1'b0;
        set_idle();
        step("post_arst");
        re = 2'b11; raddr = 4'b1101;
        step("post_arst_rd");

        // Synchronous clear wins over same-edge writes and reads
        set_idle(); we = 2'b01; waddr = 4'h2; wdata = 16'h0077; wmask = 16'h00FF;
        step("pre_srst");
        re = 2'b01; raddr = 4'h2;
        step("pre_srst_rd");
        rst = 1'b1; we = 2'b11; waddr = 4'b0110; wdata = 16'h5555; wmask = 16'hFFFF;
        re = 2'b11; raddr = 4'b0110;
        step("srst");
        chk("srst_rvalid", 32'(rvalid), 32'h0);
        set_idle(); re = 2'b11; raddr = 4'b0110;
        step("post_srst_rd");
        chk("srst_e2", 32'(rdata[7:0]), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
